// File: rtl/dtanh_grad_mul_stage_pkg.sv
// Shared fp32 constants, field view and classification helpers for the tanh
// backprop datapath.
package dtanh_grad_mul_stage_pkg;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
    localparam int unsigned FP32_BIAS    = 127;
    localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] DTANH_SAT    = 32'h322B_CC77;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    function automatic fp32_t fp32_fields(input logic [31:0] v);
        return fp32_t'(v);
    endfunction

    // Subnormals classify as zero: this datapath flushes them on input.
    function automatic fp_class_e fp32_class(input fp32_t v);
        if (v.exp == '0)
            return FP_ZERO;
        if (v.exp == '1)
            return (v.man == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    function automatic logic [23:0] fp32_sig(input fp32_t v);
        return {1'b1, v.man};
    endfunction

endpackage

// File: rtl/dtanh_grad_mul_stage_fp32_mul_rne.sv
// Combinational fp32 multiply (dtanh value x gradient) with round-to-nearest-even,
// flush-to-zero on subnormal inputs/results and saturating specials.
module fp32_mul_rne
    import dtanh_grad_mul_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    fp32_t            fa;
    fp32_t            fb;
    fp_class_e        ca;
    fp_class_e        cb;
    logic             sign;
    logic [47:0]      prod;
    logic             norm_shift;
    logic [22:0]      mant_trunc;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [23:0]      mant_rnd;
    logic signed [9:0] exp_sum;
    logic signed [9:0] exp_fin;
    logic             unused_sign_a;

    // The dtanh operand is non-negative, so only the gradient sign matters.
    assign unused_sign_a = fa.sign;

    always_comb begin
        fa   = fp32_fields(a);
        fb   = fp32_fields(b);
        ca   = fp32_class(fa);
        cb   = fp32_class(fb);
        sign = fb.sign;

        prod       = 48'(fp32_sig(fa)) * 48'(fp32_sig(fb));
        norm_shift = prod[47];
        exp_sum    = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp})
                     - $signed(10'(FP32_BIAS));

        if (norm_shift) begin
            mant_trunc = prod[46:24];
            guard      = prod[23];
            sticky     = |prod[22:0];
        end else begin
            mant_trunc = prod[45:23];
            guard      = prod[22];
            sticky     = |prod[21:0];
        end

        round_up = guard & (sticky | mant_trunc[0]);
        // Fraction overflow into bit 23 means the significand rounded up to 2.0:
        // the fraction bits are then all zero, so only the exponent moves.
        mant_rnd = {1'b0, mant_trunc} + 24'(round_up);
        exp_fin  = exp_sum + $signed({9'b0, norm_shift}) + $signed({9'b0, mant_rnd[23]});

        if (ca == FP_NAN || cb == FP_NAN)
            p = FP32_QNAN;
        else if (ca == FP_INF || cb == FP_INF)
            p = {sign, FP32_POS_INF[30:0]};
        else if (ca == FP_ZERO || cb == FP_ZERO)
            p = {sign, 31'b0};
        else if (exp_fin >= 10'sd255)
            p = {sign, FP32_POS_INF[30:0]};
        else if (exp_fin <= 10'sd0)
            p = {sign, 31'b0};
        else
            p = {sign, exp_fin[7:0], mant_rnd[22:0]};
    end

endmodule

// File: rtl/dtanh_grad_mul_stage.sv
// Tanh backprop stage: drives the enable-stalled dtanh lookup, delays the gradient
// to match it and emits delta = dtanh(x) * g over valid/ready.
module dtanh_grad_mul_stage
    import dtanh_grad_mul_stage_pkg::*;
#(
    parameter int unsigned DTANH_LAT = 4,
    parameter int unsigned X_W       = 16,
    parameter int unsigned G_W       = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] in_x,
    input  logic [G_W-1:0] in_grad,
    output logic [X_W-1:0] dtanh_x,
    output logic           dtanh_en,
    input  logic [G_W-1:0] dtanh_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [G_W-1:0] out_data
);

    logic                 adv;
    logic [DTANH_LAT-1:0] vld;
    logic [G_W-1:0]       gdly [DTANH_LAT];
    logic [G_W-1:0]       prod;

    // One global advance: a held output freezes this stage and the dtanh pipe together.
    assign adv      = ~out_valid | out_ready;
    assign dtanh_en = adv;
    assign in_ready = adv;
    assign dtanh_x  = in_x;

    fp32_mul_rne u_mul (
        .a (dtanh_y),
        .b (gdly[DTANH_LAT-1]),
        .p (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int unsigned i = 0; i < DTANH_LAT; i++)
                gdly[i] <= '0;
        end else if (adv) begin
            vld     <= {vld[DTANH_LAT-2:0], in_valid};
            gdly[0] <= in_grad;
            for (int unsigned i = 1; i < DTANH_LAT; i++)
                gdly[i] <= gdly[i-1];
            out_valid <= vld[DTANH_LAT-1];
            if (vld[DTANH_LAT-1])
                out_data <= prod;
        end
    end

endmodule
